// File: rtl/sram_mbank_fsm_pkg.sv
// Shared definitions for the multi-bank SRAM sequencer: FSM state encodings
// (same values as the single-bank wait-state FSM) and a bank-index width helper.
package sram_mbank_fsm_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  // Bank index width: at least one bit so a single-bank build still has a field.
  function automatic int bidx_width(input int n_banks);
    return (n_banks <= 2) ? 1 : $clog2(n_banks);
  endfunction

endpackage

// File: rtl/sram_mbank_fsm_if.sv
// abus slave-port bundle: request strobe, direction and address from the
// master, acknowledge and error back from the slave.
interface sram_mbank_fsm_if #(
  parameter int ADDR_W = 16
);
  logic              sreq;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic              sack;
  logic              serr;

  modport master (output sreq, output wr, output addr, input sack, input serr);
  modport slave  (input sreq, input wr, input addr, output sack, output serr);
endinterface

// File: rtl/sram_wait_counter.sv
// Wait-state down-counter: loaded at request acceptance, decremented while the
// FSM waits, saturating at zero so it can never wrap.
module sram_wait_counter #(
  parameter int WAIT_W = 4
) (
  input  logic              abus_clk,
  input  logic              abus_rstb,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              counter_le1
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // Next count: a load wins over a decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared by the abus reset.
  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign counter_le1 = (cnt_q <= WAIT_W'(1));

endmodule

// File: rtl/sram_mbank_fsm.sv
// Multi-bank SRAM slave sequencer. Decodes an abus request into one of
// N_BANKS banks, holds chip-select for a programmable number of wait cycles
// and acknowledges; out-of-range addresses get an error acknowledge.
// All outputs come from registered state and latches only.
module sram_mbank_fsm
  import sram_mbank_fsm_pkg::*;
#(
  parameter int                N_BANKS   = 2,
  parameter int                ADDR_W    = 16,
  parameter int                BANK_AW   = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
  parameter int                WAIT_W    = 4
) (
  input  logic                 abus_clk,
  input  logic                 abus_rstb,
  sram_mbank_fsm_if.slave      abus,
  input  logic [WAIT_W-1:0]    cfg_rd_wait,
  input  logic [WAIT_W-1:0]    cfg_wr_wait,
  output logic [N_BANKS-1:0]   sram_cs,
  output logic                 sram_we,
  output logic [BANK_AW-1:0]   sram_addr,
  output logic [1:0]           current_state
);

  localparam int BIDX_W = bidx_width(N_BANKS);
  localparam int UB     = BANK_AW + BIDX_W;

  logic [1:0]         state_q, state_d;
  logic [BIDX_W-1:0]  bank_q, bank_d;
  logic [BANK_AW-1:0] addr_q, addr_d;
  logic               wr_q, wr_d;

  logic               cnt_load;
  logic [WAIT_W-1:0]  cnt_load_val;
  logic               cnt_dec;
  logic               counter_le1;

  logic [BIDX_W-1:0]  req_bidx;
  logic               req_in_range;
  logic               active;

  assign req_bidx     = abus.addr[UB-1:BANK_AW];
  // In range: same region as BASE_ADDR above the bank field, and an existing bank.
  assign req_in_range = ((abus.addr >> UB) == (BASE_ADDR >> UB)) &&
                        ({1'b0, req_bidx} < (BIDX_W + 1)'(N_BANKS));

  // FSM next state, request latches and counter control.
  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      S_WAIT: begin
        // Requests arriving here are protocol violations and are dropped.
        cnt_dec = 1'b1;
        if (counter_le1) begin
          state_d = S_SAMPLE;
        end
      end
      default: begin
        // IDLE, SAMPLE and ERROR all accept a new request, enabling back-to-back.
        if (abus.sreq) begin
          if (req_in_range) begin
            bank_d       = req_bidx;
            addr_d       = abus.addr[BANK_AW-1:0];
            wr_d         = abus.wr;
            cnt_load     = 1'b1;
            cnt_load_val = abus.wr ? cfg_wr_wait : cfg_rd_wait;
            state_d      = (cnt_load_val != '0) ? S_WAIT : S_SAMPLE;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and request latches; async reset so chip-select drops immediately.
  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
    end
  end

  sram_wait_counter #(
    .WAIT_W (WAIT_W)
  ) u_wait_counter (
    .abus_clk    (abus_clk),
    .abus_rstb   (abus_rstb),
    .load        (cnt_load),
    .load_val    (cnt_load_val),
    .dec         (cnt_dec),
    .counter_le1 (counter_le1)
  );

  assign active        = (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign sram_cs       = active ? (N_BANKS'(1) << bank_q) : '0;
  assign sram_we       = wr_q & active;
  assign sram_addr     = addr_q;
  assign abus.sack     = (state_q == S_SAMPLE) || (state_q == S_ERROR);
  assign abus.serr     = (state_q == S_ERROR);
  assign current_state = state_q;

endmodule

// File: tb/tb_sram_mbank_fsm.sv
// Bench for sram_mbank_fsm: directed requests push expected acknowledges into
// a scoreboard; an independent monitor pops and compares on every abus_sack.
module tb_sram_mbank_fsm;

  logic       abus_clk;
  logic       abus_rstb;
  logic [3:0] cfg_rd_wait;
  logic [3:0] cfg_wr_wait;
  logic [1:0] sram_cs;
  logic       sram_we;
  logic [9:0] sram_addr;
  logic [1:0] current_state;

  int cyc;
  int total;
  int bad;

  typedef struct {
    int         cyc;
    logic       serr;
    logic [1:0] cs;
    logic       we;
    logic [9:0] addr;
  } exp_t;

  exp_t sb_q[$];

  sram_mbank_fsm_if #(.ADDR_W(16)) abus ();

  sram_mbank_fsm #(
    .N_BANKS   (2),
    .ADDR_W    (16),
    .BANK_AW   (10),
    .BASE_ADDR (16'h0000),
    .WAIT_W    (4)
  ) dut (
    .abus_clk      (abus_clk),
    .abus_rstb     (abus_rstb),
    .abus          (abus),
    .cfg_rd_wait   (cfg_rd_wait),
    .cfg_wr_wait   (cfg_wr_wait),
    .sram_cs       (sram_cs),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .current_state (current_state)
  );

  initial abus_clk = 1'b0;
  always #5 abus_clk = ~abus_clk;

  initial cyc = 0;
  always @(posedge abus_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request at a negedge; ack expected after the edge that accepts it
  // plus nwait cycles (nwait = 0 for an error response).
  task automatic issue(input logic wr, input logic [15:0] addr, input int nwait,
                       input logic serr, input logic [1:0] cs, input logic we,
                       input logic [9:0] a10);
    exp_t e;
    abus.sreq = 1'b1;
    abus.wr   = wr;
    abus.addr = addr;
    e.cyc  = cyc + 1 + nwait;
    e.serr = serr;
    e.cs   = cs;
    e.we   = we;
    e.addr = a10;
    sb_q.push_back(e);
  endtask

  // Monitor: every acknowledge must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge abus_clk);
      if (abus.serr === 1'b1 && abus.sack !== 1'b1) check("serr_without_ack", abus.sack, 1);
      if (abus.sack === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", abus.sack, 0);
        end else begin
          e = sb_q.pop_front();
          check("ack_cycle", cyc, e.cyc);
          check("ack_serr", abus.serr, e.serr);
          check("ack_cs", sram_cs, e.cs);
          check("ack_we", sram_we, e.we);
          check("ack_addr", sram_addr, e.addr);
        end
      end
    end
  end

  initial begin
    total       = 0;
    bad         = 0;
    abus_rstb   = 1'b0;
    abus.sreq   = 1'b0;
    abus.wr     = 1'b0;
    abus.addr   = '0;
    cfg_rd_wait = '0;
    cfg_wr_wait = '0;

    // Reset held, then released and idle for five cycles.
    repeat (3) @(negedge abus_clk);
    check("rst_cs", sram_cs, 0);
    check("rst_state", current_state, 0);
    abus_rstb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge abus_clk);
      check("idle_cs", sram_cs, 0);
      check("idle_we", sram_we, 0);
      check("idle_addr", sram_addr, 0);
      check("idle_sack", abus.sack, 0);
      check("idle_state", current_state, 0);
    end

    // Read bank 1 offset 0x005, wait 3: chip-select 2'b10 for four cycles.
    cfg_rd_wait = 4'd3;
    issue(1'b0, 16'h0405, 3, 1'b0, 2'b10, 1'b0, 10'h005);
    @(negedge abus_clk);
    abus.sreq = 1'b0;
    check("rd3_state_wait", current_state, 1);
    for (int i = 0; i < 4; i++) begin
      check("rd3_cs", sram_cs, 2'b10);
      check("rd3_we", sram_we, 0);
      @(negedge abus_clk);
    end
    check("rd3_cs_after", sram_cs, 0);
    check("rd3_addr_held", sram_addr, 10'h005);
    repeat (2) @(negedge abus_clk);

    // Zero-wait write then a read issued in the write's ack cycle.
    cfg_wr_wait = 4'd0;
    cfg_rd_wait = 4'd0;
    issue(1'b1, 16'h0012, 0, 1'b0, 2'b01, 1'b1, 10'h012);
    @(negedge abus_clk);
    issue(1'b0, 16'h0433, 0, 1'b0, 2'b10, 1'b0, 10'h033);
    @(negedge abus_clk);
    abus.sreq = 1'b0;
    @(negedge abus_clk);
    check("b2b_idle_we", sram_we, 0);
    repeat (2) @(negedge abus_clk);

    // Out-of-range address: error ack, no chip-select, latches keep 0x033.
    issue(1'b0, 16'h0800, 0, 1'b1, 2'b00, 1'b0, 10'h033);
    @(negedge abus_clk);
    abus.sreq = 1'b0;
    check("err_state", current_state, 3);
    @(negedge abus_clk);
    check("err_cs_after", sram_cs, 0);
    repeat (2) @(negedge abus_clk);

    // Wait 7 kept despite config change and a stray request mid-wait.
    cfg_rd_wait = 4'd7;
    issue(1'b0, 16'h0077, 7, 1'b0, 2'b01, 1'b0, 10'h077);
    @(negedge abus_clk);
    abus.sreq   = 1'b0;
    cfg_rd_wait = 4'd1;
    repeat (2) @(negedge abus_clk);
    abus.sreq = 1'b1;
    abus.wr   = 1'b1;
    abus.addr = 16'h0800;
    check("stray_cs", sram_cs, 2'b01);
    @(negedge abus_clk);
    abus.sreq = 1'b0;
    check("stray_we", sram_we, 0);
    repeat (8) @(negedge abus_clk);

    // Write to the last word of bank 1 with wait 2.
    cfg_wr_wait = 4'd2;
    issue(1'b1, 16'h07FF, 2, 1'b0, 2'b10, 1'b1, 10'h3FF);
    @(negedge abus_clk);
    abus.sreq = 1'b0;
    check("wr2_we", sram_we, 1);
    repeat (4) @(negedge abus_clk);

    // Reset during a wait: chip-select drops at once, no ack afterwards.
    cfg_rd_wait = 4'd5;
    abus.sreq = 1'b1;
    abus.wr   = 1'b0;
    abus.addr = 16'h0401;
    @(negedge abus_clk);
    abus.sreq = 1'b0;
    @(negedge abus_clk);
    check("abort_cs_before", sram_cs, 2'b10);
    #2;
    abus_rstb = 1'b0;
    #1;
    check("abort_cs_async", sram_cs, 0);
    check("abort_state", current_state, 0);
    @(negedge abus_clk);
    abus_rstb = 1'b1;
    repeat (10) @(negedge abus_clk);
    check("abort_state_after", current_state, 0);
    check("abort_addr_cleared", sram_addr, 0);

    @(negedge abus_clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_mbank_fsm.md
# sram_mbank_fsm

Multi-bank SRAM slave sequencer on the abus, and successor to the single-bank wait-state FSM. It decodes an incoming request into one of `N_BANKS` SRAM banks and applies a runtime-programmable wait count, with separate read and write values. It answers out-of-range accesses with an error response and accepts back-to-back requests without returning to idle. It sits between the abus slave port and the SRAM macro chip-selects.

## Interface
Parameters:
- `N_BANKS`, 2: number of SRAM banks, range 1..8
- `ADDR_W`, 16: abus address width
- `BANK_AW`, 10: word address width of one bank (2^`BANK_AW` words per bank)
- `BASE_ADDR`, 16'h0000: first address of bank 0; aligned to 2^(`BANK_AW`+`BIDX_W`)
- `WAIT_W`, 4: width of wait-count configuration and internal counter

Ports:
- `abus_clk`  in  1  clock
- `abus_rstb`  in  1  reset, asynchronous, active-low
- `abus_sreq`  in  1  request strobe, one cycle per request
- `abus_wr`  in  1  1 = write, 0 = read; qualified by `abus_sreq`
- `abus_addr`  in  `ADDR_W`  request address; qualified by `abus_sreq`
- `cfg_rd_wait`  in  `WAIT_W`  read wait cycles
- `cfg_wr_wait`  in  `WAIT_W`  write wait cycles
- `abus_sack`  out  1  transaction complete, one cycle
- `abus_serr`  out  1  error response; only ever high together with `abus_sack`
- `sram_cs`  out  `N_BANKS`  one-hot bank chip-select
- `sram_we`  out  1  write enable to the selected bank
- `sram_addr`  out  `BANK_AW`  word address inside the bank
- `current_state`  out  2  FSM state, for debug and observability

## Operation
- `BIDX_W` = max(1, clog2(`N_BANKS`)). Bank index = `abus_addr`[`BANK_AW`+`BIDX_W`-1:`BANK_AW`].
- A request is in range when both hold:
  - upper address bits above the bank index equal those of `BASE_ADDR`;
  - bank index < `N_BANKS`.
- States: `S_IDLE`=0, `S_WAIT`=1, `S_SAMPLE`=2, `S_ERROR`=3.
- Accept decision, taken in `S_IDLE`, `S_SAMPLE` and `S_ERROR`:
  - `abus_sreq` high and in range:
    - latch bank, `abus_addr`[`BANK_AW`-1:0] and `abus_wr`;
    - load counter with `cfg_wr_wait` or `cfg_rd_wait` according to `abus_wr`;
    - go to `S_WAIT` if the loaded value > 0, else to `S_SAMPLE`.
  - `abus_sreq` high and out of range: go to `S_ERROR`; latches unchanged.
  - `abus_sreq` low: go to `S_IDLE`.
- `S_WAIT`:
  - counter decrements each cycle;
  - go to `S_SAMPLE` when counter ≤ 1, else stay.
- `abus_sreq` during `S_WAIT` is a protocol violation: ignored, and it does not affect the transaction in flight.
- Config inputs are sampled only at acceptance. Changing them mid-transaction has no effect on that transaction.
- Outputs:
  - `sram_cs`[bank] = 1 in `S_WAIT` and `S_SAMPLE`; all zeros otherwise.
  - `sram_we` = latched wr AND (`S_WAIT` or `S_SAMPLE`).
  - `sram_addr` holds the latched address; it is not cleared after the transaction.
  - `abus_sack` = `S_SAMPLE` or `S_ERROR`.
  - `abus_serr` = `S_ERROR`.
- All outputs are decoded from registered state and latches; no combinational path from abus inputs to outputs.

## Timing
- Reset values: state `S_IDLE`, counter 0, latches 0. All outputs 0 and `current_state`=0.
- Read/write accepted at edge k with wait N > 0:
  - `S_WAIT` for cycles k+1..k+N;
  - `S_SAMPLE`/`abus_sack` at cycle k+N+1.
- With N = 0, `abus_sack` is at cycle k+1.
- Error: `abus_sack`=`abus_serr`=1 at cycle k+1.
- Back-to-back: a new `abus_sreq` in the `abus_sack` cycle is accepted at that edge. Throughput is 1 transaction per cycle at wait 0.
- Reset mid-transaction: immediate return to reset values. `sram_cs` drops asynchronously; no `abus_sack` is issued for the aborted access.
- Counter never underflows; the maximum wait is 2^`WAIT_W`-1 cycles.

## Structure
- `designs/sram/sram_encoding.vh` holds the `S_IDLE`/`S_WAIT`/`S_SAMPLE`/`S_ERROR` localparams, shared with the existing FSM.
- Sub-module `sram_wait_counter`:
  - inputs: load, load value, decrement enable;
  - output: `counter_le1` flag;
  - width `WAIT_W`.
- Top level holds the FSM, bank decode and request latches.

## Test plan
- Reset release, idle 5 cycles → all outputs 0, `current_state`=0.
- Read to bank 1 addr 0x0405, `cfg_rd_wait`=3 → `sram_cs`=2'b10 for 4 cycles, `sram_addr`=0x005, `sram_we`=0, `abus_sack` at cycle k+4.
- Write to bank 0, `cfg_wr_wait`=0, followed immediately by a read on the `abus_sack` cycle → acks at k+1 and k+2, `sram_we` high only in the first.
- Address 0x0800 with `N_BANKS`=2 → `abus_sack`=`abus_serr`=1 at k+1, `sram_cs`=0 throughout.
- `cfg_rd_wait` changed 7→1 during `S_WAIT` → original 7-cycle wait kept; a stray `abus_sreq` in `S_WAIT` is ignored.
- `abus_rstb` low during `S_WAIT` → `sram_cs`=0 immediately, no `abus_sack` after release.
